// File: rtl/mod3_pkg.sv
// Shared types and residue helpers for the mod-3 frame transmitter
// and its matching receive-side detector.
package mod3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CHECK
  } state_e;

  // (2r + b) mod 3 for r in 0..2
  function automatic logic [1:0] next_residue(
    input logic [1:0] r,
    input logic       b
  );
    logic [2:0] v;
    logic [1:0] res;
    v = {r, b};
    case (v)
      3'd0:    res = 2'd0;
      3'd1:    res = 2'd1;
      3'd2:    res = 2'd2;
      3'd3:    res = 2'd0;
      3'd4:    res = 2'd1;
      3'd5:    res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] check_bits(
    input logic [1:0] r
  );
    logic [1:0] c;
    case (r)
      2'd1:    c = 2'b10;
      2'd2:    c = 2'b01;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mod3_check_tx_residue.sv
// Running mod-3 residue of an MSB-first bit stream.
// Clear has priority over enable.
module mod3_residue
  import mod3_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [1:0] r_o
);

  logic [1:0] r_q, r_d;

  always_comb begin
    r_d = r_q;
    if (clr_i)
      r_d = 2'd0;
    else if (en_i)
      r_d = next_residue(r_q, bit_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_q <= 2'd0;
    else
      r_q <= r_d;
  end

  assign r_o = r_q;

endmodule

// File: rtl/mod3_check_tx.sv
// Serial frame transmitter: payload MSB-first plus two check bits
// that make the whole frame a multiple of 3.
module mod3_check_tx
  import mod3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             sof,
  output logic             eof
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [1:0]       r;
  logic [1:0]       code;
  logic             chk2;
  logic             accept;

  // counter reads 0/1 during CHECK to pick c[1] then c[0]
  assign chk2     = (state_q == CHECK) && (cnt_q == CW'(1));
  assign in_ready = (state_q == IDLE) || chk2;
  assign accept   = in_ready && in_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = DATA;
      DATA:    if (cnt_q == LAST) state_d = CHECK;
      CHECK:   if (chk2) state_d = in_valid ? DATA : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (accept) begin
      sh_d  = in_data;
      cnt_d = '0;
    end else begin
      unique case (state_q)
        DATA: begin
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
          cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
        CHECK:   cnt_d = chk2 ? '0 : cnt_q + CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  mod3_residue u_res (
    .clk_i  (clk),
    .rst_ni (resetn),
    .clr_i  (accept),
    .en_i   (state_q == DATA),
    .bit_i  (sh_q[WIDTH-1]),
    .r_o    (r)
  );

  always_comb begin
    code       = check_bits(r);
    dout       = 1'b0;
    dout_valid = 1'b0;
    sof        = 1'b0;
    eof        = 1'b0;
    unique case (state_q)
      DATA: begin
        dout_valid = 1'b1;
        dout       = sh_q[WIDTH-1];
        sof        = (cnt_q == '0);
      end
      CHECK: begin
        dout_valid = 1'b1;
        dout       = chk2 ? code[0] : code[1];
        eof        = chk2;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mod3_check_tx.sv
// Scoreboard bench for mod3_check_tx: arithmetic frame model,
// decoupled driver and negedge monitor.
module tb_mod3_check_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         dout;
  logic         dout_valid;
  logic         sof;
  logic         eof;

  int checks = 0;
  int errors = 0;

  // each entry: {dout, sof, eof}
  logic [2:0] q[$];
  int         acc = 0;

  always #5 clk = ~clk;

  mod3_check_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sof        (sof),
    .eof        (eof)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // frame = payload*4 + c, c chosen so the frame is a multiple of 3
  task automatic push_frame(input logic [W-1:0] w);
    int         c;
    logic [1:0] cb;
    c  = (3 - (int'(w) % 3)) % 3;
    cb = 2'(c);
    for (int i = W - 1; i >= 0; i--)
      q.push_back({w[i], (i == W - 1), 1'b0});
    q.push_back({cb[1], 1'b0, 1'b0});
    q.push_back({cb[0], 1'b0, 1'b1});
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    if (!resetn) begin
      chk("rst_out", {3'b0, dout, dout_valid, sof, eof, in_ready},
          8'b0000_0001);
    end else begin
      chk("in_ready", {7'b0, in_ready}, {7'b0, (q.size() <= 1)});
      if (q.size() == 0) begin
        chk("idle_out", {4'b0, dout, dout_valid, sof, eof}, 8'h0);
      end else begin
        e = q.pop_front();
        chk("frame_bit", {4'b0, dout_valid, dout, sof, eof},
            {4'b0, 1'b1, e});
        if (sof) acc = 0;
        acc = (acc * 2 + int'(dout)) % 3;
        if (e[0]) chk("div3", 8'(acc), 8'd0);
      end
    end
  end

  task automatic xfer(input logic [W-1:0] w);
    int   n = 0;
    logic rdy;
    forever begin
      @(negedge clk);
      #1;
      rdy      = in_ready;
      in_valid = 1'b1;
      in_data  = rdy ? w : W'($urandom);
      @(posedge clk);
      if (rdy) begin
        push_frame(w);
        break;
      end
      n++;
      if (n > 4 * W) begin
        chk("accept_timeout", 8'd0, 8'd1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 4 * W) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 8'(q.size()), 8'd0);
  endtask

  initial begin
    logic [W-1:0] dir[5];
    dir = '{8'h05, 8'h07, 8'h01, 8'h00, 8'hFF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    idle(3);

    foreach (dir[i]) begin
      xfer(dir[i]);
      idle(W + 4);
    end

    xfer(8'h05);
    xfer(8'h07);
    idle(W + 4);

    xfer(8'h3C);
    idle(W + 4);
    xfer(8'hC3);
    idle(W + 4);

    xfer(8'hA5);
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_valid", {7'b0, dout_valid}, 8'd1);
    resetn = 1'b0;
    in_valid = 1'b0;
    q.delete();
    #1;
    chk("async_rst", {3'b0, dout, dout_valid, sof, eof, in_ready},
        8'b0000_0001);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    idle(2);
    xfer(8'h05);
    idle(W + 4);

    for (int k = 0; k < 150; k++) begin
      xfer(W'($urandom));
      if ($urandom_range(0, 2) == 0)
        idle($urandom_range(0, 12));
    end
    idle(1);
    drain();
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end

endmodule
